// File: rtl/dispatch_demux4.sv
// dispatch_demux4: registered 1-to-4 valid/ready demultiplexer with a
// 2-entry FIFO per destination lane, so back-pressure on one lane never
// stalls traffic bound for the others.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush of every lane
//   in_valid/in_ready     upstream handshake; in_sel picks lane, in_data payload
//   out_valid[3:0]        per-lane head valid
//   out_ready[3:0]        per-lane consumer takes head
//   out_data0..3          per-lane head payload (don't-care when not valid)
//   lane_full[3:0]        per-lane "holds 2 entries" status
module dispatch_demux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       lane_full
);

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 2;

  logic [LANES-1:0][1:0] cnt_q, cnt_d;
  logic [LANES-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LANES-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LANES-1:0]      push_v, pop_v;
  logic                  push;

  // Payload storage; deliberately not reset, only occupancy state is.
  logic [WIDTH-1:0] mem_q [LANES][DEPTH];

  // Acceptance depends only on registered occupancy, in_sel and flush.
  always_comb begin
    in_ready = !flush && (cnt_q[in_sel] != 2'd2);
    push     = in_valid && in_ready;
  end

  // Per-lane status derived from registered counts.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      out_valid[i] = (cnt_q[i] != 2'd0);
      lane_full[i] = (cnt_q[i] == 2'd2);
    end
  end

  always_comb begin
    out_data0 = mem_q[0][rd_ptr_q[0]];
    out_data1 = mem_q[1][rd_ptr_q[1]];
    out_data2 = mem_q[2][rd_ptr_q[2]];
    out_data3 = mem_q[3][rd_ptr_q[3]];
  end

  // Next occupancy and pointers; flush overrides any push or pop.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push_v   = '0;
    pop_v    = '0;
    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        push_v[i] = push && (in_sel == 2'(i));
        pop_v[i]  = out_valid[i] && out_ready[i];
        if (push_v[i]) wr_ptr_d[i] = ~wr_ptr_q[i];
        if (pop_v[i])  rd_ptr_d[i] = ~rd_ptr_q[i];
        case ({push_v[i], pop_v[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
          2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Write the accepted payload into the selected lane's tail slot.
  always_ff @(posedge clk) begin
    if (push) mem_q[in_sel][wr_ptr_q[in_sel]] <= in_data;
  end

endmodule

// File: tb/tb_dispatch_demux4.sv
module tb_dispatch_demux4;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       lane_full;

  dispatch_demux4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .lane_full(lane_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: one queue per lane holding the buffered payloads in order.
  logic [WIDTH-1:0] q [4][$];
  int pushes [4];

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  ordy;
    logic        fl;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_full;
  } vec_t;

  vec_t vecs [13];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] head(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] ordy, input logic fl);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Compare every DUT output against the lane queues.
  task automatic check_model();
    logic [3:0] ev, ef;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (q[i].size() != 0);
      ef[i] = (q[i].size() == 2);
    end
    cmp("model_out_valid", 32'(out_valid), 32'(ev));
    cmp("model_lane_full", 32'(lane_full), 32'(ef));
    cmp("model_in_ready", 32'(in_ready), 32'(!flush && q[in_sel].size() != 2));
    for (int i = 0; i < 4; i++)
      if (ev[i]) cmp($sformatf("model_head%0d", i), head(i), q[i][0]);
  endtask

  // Apply the current inputs to the queues as the coming edge will.
  task automatic model_step();
    logic do_push;
    if (flush) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      do_push = in_valid && (q[in_sel].size() != 2);
      for (int i = 0; i < 4; i++)
        if (out_ready[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (do_push) begin
        q[in_sel].push_back(in_data);
        pushes[in_sel]++;
      end
    end
  endtask

  task automatic tick();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) pushes[i] = 0;

    // Reset state
    #10;
    cmp("rst_out_valid", 32'(out_valid), 32'h0);
    cmp("rst_lane_full", 32'(lane_full), 32'h0);
    cmp("rst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Routing then back-pressure isolation on lane 2
    vecs[0]  = '{1'b1, 2'd0, 32'hA0, 4'hF,    1'b0, 1'b1, 4'b0001, 4'b0000};
    vecs[1]  = '{1'b1, 2'd1, 32'hB1, 4'hF,    1'b0, 1'b1, 4'b0010, 4'b0000};
    vecs[2]  = '{1'b1, 2'd2, 32'hC2, 4'hF,    1'b0, 1'b1, 4'b0100, 4'b0000};
    vecs[3]  = '{1'b1, 2'd3, 32'hD3, 4'hF,    1'b0, 1'b1, 4'b1000, 4'b0000};
    vecs[4]  = '{1'b0, 2'd0, 32'h00, 4'hF,    1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b1, 2'd2, 32'h11, 4'b1011, 1'b0, 1'b1, 4'b0100, 4'b0000};
    vecs[6]  = '{1'b1, 2'd2, 32'h22, 4'b1011, 1'b0, 1'b1, 4'b0100, 4'b0100};
    vecs[7]  = '{1'b1, 2'd2, 32'h33, 4'b1011, 1'b0, 1'b0, 4'b0100, 4'b0100};
    vecs[8]  = '{1'b1, 2'd1, 32'h44, 4'b1011, 1'b0, 1'b1, 4'b0110, 4'b0100};
    vecs[9]  = '{1'b0, 2'd1, 32'h00, 4'b1011, 1'b0, 1'b1, 4'b0100, 4'b0100};
    vecs[10] = '{1'b1, 2'd2, 32'h33, 4'hF,    1'b0, 1'b0, 4'b0100, 4'b0000};
    vecs[11] = '{1'b1, 2'd2, 32'h33, 4'hF,    1'b0, 1'b1, 4'b0100, 4'b0000};
    vecs[12] = '{1'b0, 2'd0, 32'h00, 4'hF,    1'b0, 1'b1, 4'b0000, 4'b0000};
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].v, vecs[k].s, vecs[k].d, vecs[k].ordy, vecs[k].fl);
      cmp($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_rdy));
      tick();
      cmp($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
      cmp($sformatf("vec%0d_lane_full", k), 32'(lane_full), 32'(vecs[k].exp_full));
    end

    // Push and pop together on lane 0 at count 1
    drive(1'b1, 2'd0, 32'h5, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd0, 32'h6, 4'b0001, 1'b0); tick();
    cmp("pp_valid0", 32'(out_valid[0]), 32'h1);
    cmp("pp_full0", 32'(lane_full[0]), 32'h0);
    cmp("pp_data0", out_data0, 32'h6);
    drive(1'b0, 2'd0, 32'h0, 4'hF, 1'b0); tick();

    // Full lane 3 drains while upstream targets it
    drive(1'b1, 2'd3, 32'h7, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd3, 32'h8, 4'h0, 1'b0); tick();
    cmp("full3_lane_full", 32'(lane_full[3]), 32'h1);
    drive(1'b1, 2'd3, 32'h9, 4'b1000, 1'b0);
    cmp("full3_in_ready", 32'(in_ready), 32'h0);
    tick();
    cmp("drain3_full", 32'(lane_full[3]), 32'h0);
    cmp("drain3_valid", 32'(out_valid[3]), 32'h1);
    cmp("drain3_data", out_data3, 32'h8);

    // Flush with lanes 0 and 1 occupied
    drive(1'b1, 2'd0, 32'h21, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'h31, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd2, 32'h41, 4'hF, 1'b1);
    cmp("flush_in_ready", 32'(in_ready), 32'h0);
    cmp("flush_pre_valid", 32'(out_valid), 32'b1011);
    tick();
    cmp("flush_post_valid", 32'(out_valid), 32'h0);
    cmp("flush_post_full", 32'(lane_full), 32'h0);

    // Asynchronous reset between edges with lanes full
    drive(1'b1, 2'd0, 32'h51, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd0, 32'h52, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'h53, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'h54, 4'h0, 1'b0); tick();
    drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
    cmp("pre_arst_full", 32'(lane_full), 32'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_out_valid", 32'(out_valid), 32'h0);
    cmp("arst_lane_full", 32'(lane_full), 32'h0);
    for (int i = 0; i < 4; i++) q[i].delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic until every lane has taken at least 1000 payloads
    for (int i = 0; i < 4; i++) pushes[i] = 0;
    for (int c = 0; c < 20000; c++) begin
      if (pushes[0] >= 1000 && pushes[1] >= 1000 && pushes[2] >= 1000 && pushes[3] >= 1000)
        break;
      drive(1'b1 & ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), $urandom(),
            4'($urandom()), 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++)
      cmp($sformatf("rand_push_budget%0d", i), 32'(pushes[i] >= 1000), 32'h1);

    // Drain everything and confirm nothing is left
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);
      tick();
    end
    cmp("final_empty", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
